// File: rtl/sp_ram_pkg.sv
// Shared definitions for the single-port RAM round-robin controller:
// RDWEN encodings, parameter limits and the requester-ID width helper.
package sp_ram_pkg;

  typedef enum logic {
    SP_RAM_RD = 1'b0,
    SP_RAM_WR = 1'b1
  } rdwen_e;

  localparam int MAX_NUM_REQ = 8;
  localparam int MAX_RAM_LAT = 2;

  // A single requester still needs one ID bit so vectors never collapse to zero width.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_rr_arb.sv
// Rotate-priority picker: first valid requester at or after rr_ptr_i, wrapping.
// Purely combinational; the caller owns the pointer.
module sp_ram_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    win_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
      end
    end
  end

endmodule

// File: rtl/sp_ram_rr_ctrl.sv
// Round-robin sharing of one single-port RAM among NUM_REQ valid/ready requesters.
// Define SP_RAM_RR_CTRL_PERF_EN to add saturating read/write/stall counters.
module sp_ram_rr_ctrl
  import sp_ram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_LAT    = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_bw,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          ram_ce,
  output logic                          ram_rdwen,
  output logic [ADDR_WIDTH-1:0]         ram_a,
  output logic [DATA_WIDTH-1:0]         ram_di,
  output logic [DATA_WIDTH-1:0]         ram_bw,
  input  logic [DATA_WIDTH-1:0]         ram_do
`ifdef SP_RAM_RR_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_rd_cnt,
  output logic [31:0]                   perf_wr_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]               win;
  logic [NUM_REQ-1:0]            gnt;
  logic                          xfer;
  logic                          rd_push;
  logic [RAM_LAT-1:0]            pipe_vld_q;
  logic [RAM_LAT-1:0][ID_W-1:0]  pipe_id_q;

  sp_ram_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid_i (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .gnt_o       (gnt),
    .win_o       (win)
  );

  assign req_ready = RST ? '0 : gnt;
  assign xfer      = |req_ready;
  assign rd_push   = xfer && (ram_rdwen == SP_RAM_RD);

  always_comb begin
    ram_ce    = xfer;
    ram_rdwen = SP_RAM_RD;
    ram_a     = '0;
    ram_di    = '0;
    ram_bw    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        ram_rdwen = req_we[i] ? SP_RAM_WR : SP_RAM_RD;
        ram_a     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_di    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        ram_bw    = req_we[i] ? req_bw[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
    end
  end

  // The read pipe tracks which requester owns the RAM output RAM_LAT cycles later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q   <= '0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      pipe_vld_q[0] <= rd_push;
      pipe_id_q[0]  <= win;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (!RST && pipe_vld_q[RAM_LAT-1]) begin
      rsp_valid[pipe_id_q[RAM_LAT-1]] = 1'b1;
      rsp_rdata                       = ram_do;
    end
  end

`ifdef SP_RAM_RR_CTRL_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;
  logic        stall;

  assign stall = |(req_valid & ~req_ready);

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (rd_push && perf_rd_q != '1) perf_rd_q <= perf_rd_q + 32'd1;
      if (xfer && !rd_push && perf_wr_q != '1) perf_wr_q <= perf_wr_q + 32'd1;
      if (stall && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_sp_ram_rr_ctrl.sv
// Bench for sp_ram_rr_ctrl (NUM_REQ=2, RAM_LAT=1) with a 1-cycle RAM model,
// directed scenarios followed by randomized traffic against a reference model.
module tb_sp_ram_rr_ctrl;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RST;
  logic [N-1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata, req_bw;
  logic [DW-1:0]     rsp_rdata;
  logic              ram_ce, ram_rdwen;
  logic [AW-1:0]     ram_a;
  logic [DW-1:0]     ram_di, ram_bw, ram_do;
`ifdef SP_RAM_RR_CTRL_PERF_EN
  logic [31:0]       perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  logic [AW-1:0]     s_addr  [N];
  logic [DW-1:0]     s_wdata [N];
  logic [DW-1:0]     s_bw    [N];

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign req_addr[g*AW +: AW]  = s_addr[g];
    assign req_wdata[g*DW +: DW] = s_wdata[g];
    assign req_bw[g*DW +: DW]    = s_bw[g];
  end

  sp_ram_rr_ctrl #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LAT(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bw(req_bw),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_ce(ram_ce), .ram_rdwen(ram_rdwen), .ram_a(ram_a),
    .ram_di(ram_di), .ram_bw(ram_bw), .ram_do(ram_do)
`ifdef SP_RAM_RR_CTRL_PERF_EN
    , .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // 1-cycle single-port RAM with per-bit write enables; ram_clr zeroes it at start.
  logic          ram_clr;
  logic [DW-1:0] ram_mem [256];
  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
    end else if (ram_ce) begin
      if (ram_rdwen) ram_mem[ram_a] <= (ram_mem[ram_a] & ~ram_bw) | (ram_di & ram_bw);
      else           ram_do <= ram_mem[ram_a];
    end
  end

  // Reference model state
  logic [DW-1:0] m_mem [256];
  int            m_ptr;
  bit            m_pv;
  int            m_pid;
  logic [DW-1:0] m_pdata;
  int            m_rd, m_wr, m_st;
  int            last_gnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input bit vv, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] b);
    req_valid[i] = vv;
    req_we[i]    = w;
    s_addr[i]    = a;
    s_wdata[i]   = d;
    s_bw[i]      = b;
  endtask

  // Check one cycle against the model, advance the model across the edge, return at negedge.
  task automatic cycle();
    int            w;
    logic [N-1:0]  er, ersp;
    #1;
    w  = RST ? -1 : pick(req_valid, m_ptr);
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("ram_ce", ram_ce, w >= 0);
    if (w >= 0) begin
      chk("ram_rdwen", ram_rdwen, req_we[w]);
      chk("ram_a", ram_a, s_addr[w]);
      chk("ram_di", ram_di, s_wdata[w]);
      chk("ram_bw", ram_bw, req_we[w] ? s_bw[w] : '0);
    end else begin
      chk("idle_bus", {ram_rdwen, ram_a, ram_di, ram_bw}, '0);
    end
    ersp = '0;
    if (m_pv && !RST) ersp[m_pid] = 1'b1;
    chk("rsp_valid", rsp_valid, ersp);
    chk("rsp_rdata", rsp_rdata, (m_pv && !RST) ? m_pdata : '0);
`ifdef SP_RAM_RR_CTRL_PERF_EN
    chk("perf_rd", perf_rd_cnt, m_rd);
    chk("perf_wr", perf_wr_cnt, m_wr);
    chk("perf_stall", perf_stall_cnt, m_st);
`endif
    if (RST) begin
      m_ptr = 0; m_pv = 1'b0; m_rd = 0; m_wr = 0; m_st = 0;
    end else begin
      m_pv = 1'b0;
      if ((req_valid & ~er) != '0) m_st++;
      if (w >= 0) begin
        if (req_we[w]) begin
          m_mem[s_addr[w]] = (m_mem[s_addr[w]] & ~s_bw[w]) | (s_wdata[w] & s_bw[w]);
          m_wr++;
        end else begin
          m_pv = 1'b1; m_pid = w; m_pdata = m_mem[s_addr[w]];
          m_rd++;
        end
        m_ptr = (w + 1) % N;
      end
    end
    last_gnt = w;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_ptr = 0; m_pv = 1'b0; m_pid = 0; m_pdata = '0;
    m_rd = 0; m_wr = 0; m_st = 0; last_gnt = -1;
    ram_clr = 1'b1;

    // Reset held with both requesters valid
    RST = 1'b1;
    set_req(0, 1'b1, 1'b0, 8'h01, '0, '0);
    set_req(1, 1'b1, 1'b0, 8'h02, '0, '0);
    cycle();
    ram_clr = 1'b0;
    cycle();
    cycle();

    // Single write then read from requester 0
    RST = 1'b0;
    set_req(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
    set_req(1, 1'b0, 1'b0, 8'h00, '0, '0);
    cycle();
    set_req(0, 1'b1, 1'b0, 8'h10, '0, '0);
    cycle();
    req_valid = '0;
    #1;
    chk("t2_rsp_valid", rsp_valid, 2'b01);
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    cycle();

    // Contention after a fresh reset: grants alternate starting at 0
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h10, '0, '0);
    set_req(1, 1'b1, 1'b0, 8'h20, '0, '0);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_ce", ram_ce, 1'b1);
      cycle();
    end

    // Partial write merges with previous contents
    set_req(1, 1'b0, 1'b0, 8'h00, '0, '0);
    set_req(0, 1'b1, 1'b1, 8'h03, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cycle();
    set_req(0, 1'b1, 1'b1, 8'h03, 32'h00000000, 32'h0000FFFF);
    cycle();
    set_req(0, 1'b1, 1'b0, 8'h03, '0, '0);
    cycle();
    req_valid = '0;
    #1;
    chk("t4_rsp_rdata", rsp_rdata, 32'hFFFF0000);
    cycle();

    // Reset while a read is in flight
    set_req(0, 1'b1, 1'b0, 8'h10, '0, '0);
    cycle();
    RST = 1'b1;
    set_req(1, 1'b1, 1'b0, 8'h03, '0, '0);
    #1;
    chk("t5_rsp_in_rst", rsp_valid, 2'b00);
    cycle();
    RST = 1'b0;
    #1;
    chk("t5_ptr_reset", req_ready, 2'b01);
    chk("t5_no_stale_rsp", rsp_valid, 2'b00);
    cycle();
    req_valid = '0;
    cycle();

    // Counter scenario: 4 reads, 2 writes, 3 stall cycles
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    set_req(0, 1'b1, 1'b0, 8'h10, '0, '0);
    set_req(1, 1'b1, 1'b0, 8'h03, '0, '0);
    repeat (3) cycle();
    set_req(1, 1'b0, 1'b0, 8'h00, '0, '0);
    cycle();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b1, 8'h05, 32'h12345678, 32'hFFFFFFFF);
    cycle();
    set_req(1, 1'b1, 1'b1, 8'h06, 32'h9ABCDEF0, 32'hFFFFFFFF);
    cycle();
    req_valid = '0;
`ifdef SP_RAM_RR_CTRL_PERF_EN
    #1;
    chk("t6_rd", perf_rd_cnt, 32'd4);
    chk("t6_wr", perf_wr_cnt, 32'd2);
    chk("t6_stall", perf_stall_cnt, 32'd3);
`endif
    cycle();

    // Randomized traffic; a stalled requester holds its request unchanged
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_gnt != i)) begin
          set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  AW'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom);
        end
      end
      cycle();
    end
    RST = 1'b0;
    req_valid = '0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
